// File: rtl/regfile_hilo_pkg.sv
// Shared register-bus definitions for the register file and HI/LO block.
// Also holds the read-source encoding used by both GPR read ports.
package regfile_hilo_pkg;

  localparam int REGBUS     = 32;
  localparam int REGADDRBUS = 5;
  localparam int REG_NUM    = 1 << REGADDRBUS;
  localparam logic [REGADDRBUS-1:0] ZERO_ADDR = '0;

  typedef enum logic [1:0] {
    RD_ZERO   = 2'd0,
    RD_BYPASS = 2'd1,
    RD_STORED = 2'd2
  } rdSrc_e;

  // Disabled ports and register 0 read zero; a same-cycle write to the address wins over storage.
  function automatic rdSrc_e readSource(input logic ren, input logic addrIsZero, input logic wbHit);
    if (!ren || addrIsZero) begin
      return RD_ZERO;
    end
    if (wbHit) begin
      return RD_BYPASS;
    end
    return RD_STORED;
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// HI/LO multiply-divide result registers with same-cycle write bypass.
// HI and LO load independently; reset clears both asynchronously.
module hilo_reg
  import regfile_hilo_pkg::*;
#(
  parameter int DW = REGBUS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_whi,
  input  logic          i_wlo,
  input  logic [DW-1:0] i_hi,
  input  logic [DW-1:0] i_lo,
  output logic [DW-1:0] o_hi,
  output logic [DW-1:0] o_lo
);

  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_whi) begin
        r_hi <= i_hi;
      end
      if (i_wlo) begin
        r_lo <= i_lo;
      end
    end
  end

  // The bypass is independent of reset, so a write in progress is visible even while held in reset.
  assign o_hi = i_whi ? i_hi : r_hi;
  assign o_lo = i_wlo ? i_lo : r_lo;

endmodule

// File: rtl/regfile_hilo.sv
// General-purpose register file (register 0 hard-wired to zero) with two
// combinational write-through read ports, plus the HI/LO sub-block.
module regfile_hilo
  import regfile_hilo_pkg::*;
#(
  parameter int DW = REGBUS,
  parameter int AW = REGADDRBUS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_wb_waddr,
  input  logic          i_wb_we,
  input  logic [DW-1:0] i_wb_wdata,
  input  logic          i_whi,
  input  logic          i_wlo,
  input  logic [DW-1:0] i_hi,
  input  logic [DW-1:0] i_lo,
  input  logic          i_re1,
  input  logic [AW-1:0] i_raddr1,
  output logic [DW-1:0] o_rdata1,
  input  logic          i_re2,
  input  logic [AW-1:0] i_raddr2,
  output logic [DW-1:0] o_rdata2,
  output logic [DW-1:0] o_hi,
  output logic [DW-1:0] o_lo
);

  localparam int NREGS = (AW == REGADDRBUS) ? REG_NUM : (1 << AW);
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_ADDR);

  logic [DW-1:0] r_gpr [NREGS];
  logic          w_wbValid;
  rdSrc_e        w_src1;
  rdSrc_e        w_src2;

  assign w_wbValid = i_wb_we && (i_wb_waddr != ZERO_A);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_wbValid) begin
      r_gpr[i_wb_waddr] <= i_wb_wdata;
    end
  end

  assign w_src1 = readSource(i_re1, i_raddr1 == ZERO_A, i_wb_we && (i_raddr1 == i_wb_waddr));
  assign w_src2 = readSource(i_re2, i_raddr2 == ZERO_A, i_wb_we && (i_raddr2 == i_wb_waddr));

  always_comb begin
    o_rdata1 = '0;
    case (w_src1)
      RD_BYPASS: o_rdata1 = i_wb_wdata;
      RD_STORED: o_rdata1 = r_gpr[i_raddr1];
      default:   o_rdata1 = '0;
    endcase
  end

  always_comb begin
    o_rdata2 = '0;
    case (w_src2)
      RD_BYPASS: o_rdata2 = i_wb_wdata;
      RD_STORED: o_rdata2 = r_gpr[i_raddr2];
      default:   o_rdata2 = '0;
    endcase
  end

  hilo_reg #(
    .DW(DW)
  ) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .i_whi(i_whi),
    .i_wlo(i_wlo),
    .i_hi (i_hi),
    .i_lo (i_lo),
    .o_hi (o_hi),
    .o_lo (o_lo)
  );

endmodule

// File: tb/tb_regfile_hilo.sv
// Scoreboard bench for regfile_hilo: directed cases followed by randomized traffic,
// checked against an array-based model of the register file and HI/LO.
module tb_regfile_hilo;

  logic        clk;
  logic        rst;
  logic [4:0]  i_wb_waddr;
  logic        i_wb_we;
  logic [31:0] i_wb_wdata;
  logic        i_whi;
  logic        i_wlo;
  logic [31:0] i_hi;
  logic [31:0] i_lo;
  logic        i_re1;
  logic [4:0]  i_raddr1;
  logic [31:0] o_rdata1;
  logic        i_re2;
  logic [4:0]  i_raddr2;
  logic [31:0] o_rdata2;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  regfile_hilo dut (
    .clk       (clk),
    .rst       (rst),
    .i_wb_waddr(i_wb_waddr),
    .i_wb_we   (i_wb_we),
    .i_wb_wdata(i_wb_wdata),
    .i_whi     (i_whi),
    .i_wlo     (i_wlo),
    .i_hi      (i_hi),
    .i_lo      (i_lo),
    .i_re1     (i_re1),
    .i_raddr1  (i_raddr1),
    .o_rdata1  (o_rdata1),
    .i_re2     (i_re2),
    .i_raddr2  (i_raddr2),
    .o_rdata2  (o_rdata2),
    .o_hi      (o_hi),
    .o_lo      (o_lo)
  );

  typedef struct {
    int          id;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] gprModel[32];
  logic [31:0] hiModel;
  logic [31:0] loModel;
  int          testsRun = 0;
  int          testsFailed = 0;
  int          txnId = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference read: disabled or r0 gives 0, a write in flight to the same address wins, else stored.
  function automatic logic [31:0] modelRead(input logic re, input logic [4:0] ra,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd);
    if (!re || ra == 5'd0) return 32'd0;
    if (we && ra == wa) return wd;
    return gprModel[ra];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) gprModel[i] = 32'd0;
    hiModel = 32'd0;
    loModel = 32'd0;
  endtask

  task automatic checkOutput(input string name, input int id, input logic [31:0] got,
                             input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s txn %0d: got %h expected %h", name, id, got, exp);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge, queues the expected outputs,
  // then lets the edge commit and updates the model.
  task automatic applyStimulus(input logic rstV, input logic weV, input logic [4:0] wa,
                               input logic [31:0] wd, input logic whiV, input logic [31:0] hiV,
                               input logic wloV, input logic [31:0] loV,
                               input logic re1V, input logic [4:0] ra1,
                               input logic re2V, input logic [4:0] ra2);
    exp_t e;
    rst        = rstV;
    i_wb_we    = weV;
    i_wb_waddr = wa;
    i_wb_wdata = wd;
    i_whi      = whiV;
    i_hi       = hiV;
    i_wlo      = wloV;
    i_lo       = loV;
    i_re1      = re1V;
    i_raddr1   = ra1;
    i_re2      = re2V;
    i_raddr2   = ra2;
    if (!rstV) clearModel();
    e.id  = txnId++;
    e.rd1 = modelRead(re1V, ra1, weV, wa, wd);
    e.rd2 = modelRead(re2V, ra2, weV, wa, wd);
    e.hi  = whiV ? hiV : hiModel;
    e.lo  = wloV ? loV : loModel;
    expQ.push_back(e);
    @(posedge clk);
    if (rstV) begin
      if (weV && wa != 5'd0) gprModel[wa] = wd;
      if (whiV) hiModel = hiV;
      if (wloV) loModel = loV;
    end
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("rdata1", e.id, o_rdata1, e.rd1);
      checkOutput("rdata2", e.id, o_rdata2, e.rd2);
      checkOutput("hi", e.id, o_hi, e.hi);
      checkOutput("lo", e.id, o_lo, e.lo);
    end
  end

  initial begin
    logic [31:0] dataA;
    logic [31:0] dataB;
    rst = 1'b0;
    i_wb_we = 1'b0; i_wb_waddr = '0; i_wb_wdata = '0;
    i_whi = 1'b0; i_wlo = 1'b0; i_hi = '0; i_lo = '0;
    i_re1 = 1'b0; i_raddr1 = '0; i_re2 = 1'b0; i_raddr2 = '0;
    clearModel();
    @(posedge clk); #1;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 1, 5'd4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 1, 5'd4);
    for (int a = 1; a < 32; a++)
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'(a), 1, 5'(31 - a + 1));

    applyStimulus(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 1, 5'd5);

    applyStimulus(1, 1, 5'd7, 32'h12345678, 0, 0, 0, 0, 1, 5'd7, 1, 5'd7);
    applyStimulus(1, 1, 5'd7, 32'h0BADF00D, 0, 0, 0, 0, 0, 5'd7, 1, 5'd7);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 5'd7);

    applyStimulus(1, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 5'd0, 1, 5'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 1, 5'd0);

    applyStimulus(1, 0, 0, 0, 1, 32'hAAAA0000, 0, 32'h11111111, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 0, 32'h22222222, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 1, 32'h00005555, 0, 0, 0, 0);

    applyStimulus(1, 1, 5'd9, 32'h55, 1, 32'h9, 1, 32'h6, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 1, 5'd5);
    applyStimulus(1, 1, 5'd9, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 1, 5'd5);
    applyStimulus(0, 1, 5'd9, 32'h99, 1, 32'h1, 1, 32'h2, 1, 5'd9, 1, 5'd9);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 1, 5'd9);

    for (int n = 0; n < 400; n++) begin
      dataA = $urandom;
      dataB = $urandom;
      applyStimulus(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), dataA,
                    1'($urandom_range(0, 1)), dataB,
                    ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 31)));
    end

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/regfile_hilo.md
REGFILE_HILO -- requirements
Module: regfile_hilo

Interface
REQ-001 Parameter: DW, default 32, data width (matches `REGBUS`).
REQ-002 Parameter: AW, default 5, register address width (matches `REGADDRBUS`); 2**AW registers.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low (rst==0 resets).
REQ-005 Port: i_wb_waddr  input  AW  write-back destination register.
REQ-006 Port: i_wb_we  input  1  write-back enable.
REQ-007 Port: i_wb_wdata  input  DW  write-back data.
REQ-008 Port: i_whi  input  1  HI write enable.
REQ-009 Port: i_wlo  input  1  LO write enable.
REQ-010 Port: i_hi  input  DW  HI write data.
REQ-011 Port: i_lo  input  DW  LO write data.
REQ-012 Port: i_re1  input  1  read port 1 enable.
REQ-013 Port: i_raddr1  input  AW  read port 1 address.
REQ-014 Port: o_rdata1  output  DW  read port 1 data.
REQ-015 Port: i_re2  input  1  read port 2 enable.
REQ-016 Port: i_raddr2  input  AW  read port 2 address.
REQ-017 Port: o_rdata2  output  DW  read port 2 data.
REQ-018 Port: o_hi  output  DW  current HI value, with bypass.
REQ-019 Port: o_lo  output  DW  current LO value, with bypass.

Function
REQ-020 Register write SHALL occur on the rising clk edge when i_wb_we==1 and i_wb_waddr!=0; it is visible in stored state from the next cycle.
REQ-021 Writes to register 0 SHALL be discarded; register 0 SHALL always read 0.
REQ-022 Read ports SHALL be combinational (zero latency) and independent; both may read the same address.
REQ-023 Read port n SHALL output 0 when i_ren==0, regardless of address.
REQ-024 When i_ren==1, i_raddrn==0, output SHALL be 0.
REQ-025 When i_ren==1, i_raddrn!=0, i_wb_we==1 and i_raddrn==i_wb_waddr, output SHALL be i_wb_wdata (same-cycle write-through bypass).
REQ-026 Otherwise read port n SHALL output the stored register i_raddrn.
REQ-027 HI SHALL load i_hi on the rising edge when i_whi==1; LO SHALL load i_lo when i_wlo==1; HI and LO are independent.
REQ-028 o_hi SHALL equal i_hi when i_whi==1, else stored HI; o_lo SHALL equal i_lo when i_wlo==1, else stored LO (combinational bypass).
REQ-029 Simultaneous GPR write, HI write, LO write and both reads in one cycle SHALL all take effect without priority interaction.
REQ-030 Writing the same register on consecutive cycles: last write wins; a read sees the stored value or the bypassed write in progress, never a stale older value.

Reset
REQ-031 While rst==0, all 2**AW registers, HI and LO SHALL be cleared to 0 asynchronously, and writes SHALL be ignored.
REQ-032 During reset, o_rdata1/o_rdata2 SHALL reflect cleared state (0) except where a bypass per REQ-025 applies; o_hi/o_lo likewise per REQ-028.
REQ-033 Deassertion of rst SHALL take effect without a clock; the first write is accepted on the first rising edge with rst==1.
REQ-034 Reset asserted mid-write SHALL leave the target register 0; the write is lost.

Structure
REQ-035 `REGBUS`, `REGADDRBUS`, register count and the zero-register address constant SHALL come from the shared definitions file; no local redefinition.
REQ-036 HI/LO storage and bypass SHALL be one sub-module, hilo_reg; GPR array and read logic stay in regfile_hilo.
REQ-037 Target size 120-250 lines total; no latches; storage in one always_ff with async active-low reset.

Verification
REQ-038 Reset then read r1..r31 on both ports -> all 0; o_hi=o_lo=0.
REQ-039 Write r5=0xDEADBEEF, next cycle read r5 on port 1 and port 2 -> both 0xDEADBEEF.
REQ-040 Same cycle write r7=0x12345678 and read r7 -> port reads 0x12345678 (bypass); read r7 with i_re1=0 -> 0.
REQ-041 Write r0=0xFFFFFFFF with bypass read of r0 -> 0 that cycle and after.
REQ-042 i_whi=1,i_hi=0xAAAA0000, i_wlo=0 -> o_hi=0xAAAA0000 same cycle, o_lo unchanged; next cycle whi=0 -> o_hi holds 0xAAAA0000.
REQ-043 Write r9=0x55, assert rst=0 mid-cycle, release -> r9 reads 0, HI/LO 0; write after release accepted on first edge.
